// File: rtl/gf2m_pkg.sv
// Shared constants, FSM encoding and GF(2) helpers for the digit-serial field multiplier.
package gf2m_pkg;

    localparam int M_B233 = 233;
    localparam logic [M_B233-1:0] POLY_B233 = (M_B233'(1) << 74) | M_B233'(1);

    // Widest intermediate product any instance may fold: M + D bits must fit.
    localparam int FOLD_W = 512;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} gf2m_state_e;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    function automatic int poly_deg(input logic [FOLD_W-1:0] p);
        int d;
        d = 0;
        for (int i = 0; i < FOLD_W; i++)
            if (p[i]) d = i;
        return d;
    endfunction

    // One reduction step: bits m..m+nhi-1 are folded back as x^m == poly.
    // The result is fully reduced only when nhi + deg(poly) <= m.
    function automatic logic [FOLD_W-1:0] gf2m_fold(input logic [FOLD_W-1:0] v,
                                                    input logic [FOLD_W-1:0] poly,
                                                    input int m, input int nhi);
        logic [FOLD_W-1:0] hi;
        logic [FOLD_W-1:0] r;
        hi = v >> m;
        r  = v & ~({FOLD_W{1'b1}} << m);
        for (int j = 0; j < FOLD_W; j++)
            if (j < nhi && hi[j]) r = r ^ (poly << j);
        return r;
    endfunction

endpackage

// File: rtl/gf2m_mul_digit.sv
// One digit step of the MSB-first multiply: acc_next = acc*x^D + A*dig, reduced mod x^M + POLY.
module gf2m_mul_digit
    import gf2m_pkg::*;
#(
    parameter int              M    = M_B233,
    parameter logic [M-1:0]    POLY = M'(POLY_B233),
    parameter int              D    = 8
) (
    input  logic [M-1:0] acc,
    input  logic [M-1:0] a,
    input  logic [D-1:0] dig,
    output logic [M-1:0] acc_next
);

    logic [FOLD_W-1:0] prod;

    // Both terms stay below x^(M+D), so a single fold of the XOR suffices.
    always_comb begin
        prod = FOLD_W'(acc) << D;
        for (int i = 0; i < D; i++)
            if (dig[i]) prod = prod ^ (FOLD_W'(a) << i);
        acc_next = M'(gf2m_fold(prod, FOLD_W'(POLY), M, D));
    end

endmodule

// File: rtl/gf2m_digit_mult.sv
// Digit-serial GF(2^M) polynomial-basis multiplier with valid/ready on both sides.
module gf2m_digit_mult
    import gf2m_pkg::*;
#(
    parameter int              M    = M_B233,
    parameter logic [M-1:0]    POLY = M'(POLY_B233),
    parameter int              D    = 8,
    localparam int             NDIG = ceil_div(M, D),
    localparam int             CW   = $clog2(NDIG + 1)
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [M-1:0]  DIN1,
    input  logic [M-1:0]  DIN2,
    input  logic          IN_VALID,
    output logic          IN_READY,
    output logic [M-1:0]  DOUT,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [CW-1:0] CNT
);

    localparam int BW = NDIG * D;

    if (D < 1 || D > M - poly_deg(FOLD_W'(POLY))) begin : g_bad_digit
        $error("gf2m_digit_mult: D=%0d must lie in 1..M-deg(POLY)", D);
    end
    if (M + D > FOLD_W) begin : g_bad_width
        $error("gf2m_digit_mult: M+D=%0d exceeds fold width %0d", M + D, FOLD_W);
    end

    gf2m_state_e   state, state_nxt;
    logic [M-1:0]  a_q, acc_q, acc_nxt, dout_q;
    logic [BW-1:0] b_q;
    logic [CW-1:0] cnt_q;
    logic          last_dig;

    assign last_dig = (cnt_q == CW'(NDIG - 1));

    gf2m_mul_digit #(.M(M), .POLY(POLY), .D(D)) u_step (
        .acc      (acc_q),
        .a        (a_q),
        .dig      (b_q[BW-1 -: D]),
        .acc_next (acc_nxt)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            dout_q <= '0;
            cnt_q  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (IN_VALID) begin
                    a_q   <= DIN1;
                    b_q   <= BW'(DIN2);  // zero pad above bit M-1 so the top digit is aligned
                    acc_q <= '0;
                    cnt_q <= '0;
                end
                ST_RUN: begin
                    acc_q <= acc_nxt;
                    b_q   <= b_q << D;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_dig) dout_q <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        case (state)
            ST_IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) state_nxt = ST_RUN;
            end
            ST_RUN:  if (last_dig) state_nxt = ST_DONE;
            ST_DONE: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign DOUT = dout_q;
    assign CNT  = cnt_q;

endmodule

// File: tb/tb_gf2m_digit_mult.sv
// Bench for gf2m_digit_mult: bit-serial reference model, per-cycle monitor and a D sweep.
module tb_gf2m_digit_mult;

    localparam int NDIG = 30;
    localparam int NSW  = 5;
    localparam logic [232:0] P_LOW = (233'(1) << 74) | 233'(1);

    logic         clk, rst_n;
    logic [232:0] din1, din2, dout;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [4:0]   cnt;

    logic [232:0]     sw_din1, sw_din2;
    logic             sw_in_valid, sw_out_ready;
    logic [NSW-1:0]   sw_in_ready, sw_out_valid;
    logic [232:0]     sw_dout [NSW];
    logic [7:0]       sw_cnt  [NSW];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    bit          mon_en = 0;

    function automatic int sw_d(input int g);
        case (g)
            0: return 1;
            1: return 7;
            2: return 8;
            3: return 32;
            default: return 159;
        endcase
    endfunction

    function automatic int sw_nd(input int g);
        return (233 + sw_d(g) - 1) / sw_d(g);
    endfunction

    gf2m_digit_mult u_dut (
        .CLK(clk), .RST_N(rst_n), .DIN1(din1), .DIN2(din2),
        .IN_VALID(in_valid), .IN_READY(in_ready), .DOUT(dout),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .CNT(cnt)
    );

    for (genvar g = 0; g < NSW; g++) begin : g_sw
        localparam int DG  = sw_d(g);
        localparam int NDG = (233 + DG - 1) / DG;
        localparam int CWG = $clog2(NDG + 1);
        logic [CWG-1:0] cnt_w;
        gf2m_digit_mult #(.D(DG)) u_sw (
            .CLK(clk), .RST_N(rst_n), .DIN1(sw_din1), .DIN2(sw_din2),
            .IN_VALID(sw_in_valid), .IN_READY(sw_in_ready[g]), .DOUT(sw_dout[g]),
            .OUT_VALID(sw_out_valid[g]), .OUT_READY(sw_out_ready), .CNT(cnt_w)
        );
        assign sw_cnt[g] = 8'(cnt_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain shift-and-add with x^233 = x^74 + 1 reduction, one bit of B at a time.
    function automatic logic [232:0] golden(input logic [232:0] a, input logic [232:0] b);
        logic [233:0] r;
        r = '0;
        for (int i = 232; i >= 0; i--) begin
            r = r << 1;
            if (r[233]) r = r ^ {1'b1, P_LOW};
            if (b[i]) r = r ^ {1'b0, a};
        end
        return r[232:0];
    endfunction

    function automatic logic [232:0] rnd233();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
        return 233'(w);
    endfunction

    task automatic chk(input string name, input logic [232:0] act, input logic [232:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Transaction-level model of the main instance: 0 idle, 1 computing, 2 holding result.
    int           m_ph = 0;
    int           m_n = 0;
    logic [232:0] m_exp = '0;
    logic [232:0] m_dout = '0;
    logic [4:0]   m_cnt = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ph   <= 0;
            m_n    <= 0;
            m_dout <= '0;
            m_cnt  <= '0;
        end else begin
            case (m_ph)
                0: if (in_valid) begin
                    m_exp <= golden(din1, din2);
                    m_n   <= 0;
                    m_cnt <= '0;
                    m_ph  <= 1;
                end
                1: begin
                    m_n   <= m_n + 1;
                    m_cnt <= 5'(m_n + 1);
                    if (m_n + 1 == NDIG) begin
                        m_ph   <= 2;
                        m_dout <= m_exp;
                    end
                end
                default: if (out_ready) m_ph <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mon_in_ready",  233'(in_ready),  233'(m_ph == 0));
            chk("mon_out_valid", 233'(out_valid), 233'(m_ph == 2));
            chk("mon_dout",      dout,            m_dout);
            chk("mon_cnt",       233'(cnt),       233'(m_cnt));
        end
    end

    task automatic start_op(input logic [232:0] a, input logic [232:0] b);
        @(negedge clk);
        din1 = a; din2 = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int last_cnt);
        lat = 0;
        last_cnt = -1;
        while (!out_valid && lat < 400) begin
            last_cnt = int'(cnt);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!out_valid) chk("timeout_out_valid", 233'(out_valid), 233'(1));
    endtask

    task automatic release_out(input int hold);
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [232:0] ra, rb, rexp;
    logic [NSW-1:0] seen;
    int lat, last_cnt, c;
    int lat_sw [NSW];

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din1 = '0; din2 = '0;
        sw_din1 = '0; sw_din2 = '0; sw_in_valid = 1'b0; sw_out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready",  233'(in_ready),  233'(1));
        chk("rst_out_valid", 233'(out_valid), 233'(0));
        chk("rst_dout",      dout,            233'(0));
        chk("rst_cnt",       233'(cnt),       233'(0));
        mon_en = 1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // identity multiply: result equals B, latency NDIG edges
        start_op(233'(1), 233'h1ABCDEF);
        wait_done(lat, last_cnt);
        chk("unit_dout", dout, 233'h1ABCDEF);
        chk("unit_lat",  233'(lat), 233'(30));
        release_out(0);

        // x^232 * x folds the top bit back to x^74 + 1
        ra = 233'(1) << 232;
        start_op(ra, 233'(2));
        wait_done(lat, last_cnt);
        chk("fold_dout", dout, (233'(1) << 74) | 233'(1));
        release_out(1);

        // zero operand; CNT seen in the final computing cycle and held in DONE
        start_op({233{1'b1}}, 233'(0));
        wait_done(lat, last_cnt);
        chk("zero_dout",     dout, 233'(0));
        chk("zero_last_cnt", 233'(last_cnt), 233'(29));
        chk("zero_done_cnt", 233'(cnt), 233'(30));
        release_out(0);

        // back-pressure and ignored inputs while busy
        ra = 233'(1) << 232;
        start_op(ra, 233'(4));
        repeat (5) @(negedge clk);
        din1 = rnd233(); din2 = rnd233(); in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        wait_done(lat, last_cnt);
        for (int i = 0; i < 5; i++) begin
            din1 = rnd233(); din2 = rnd233(); in_valid = 1'b1;
            @(negedge clk);
            chk("hold_dout",      dout, (233'(1) << 75) | 233'(2));
            chk("hold_out_valid", 233'(out_valid), 233'(1));
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("both_high_idle", 233'(in_ready), 233'(1));
        chk("both_high_cnt",  233'(cnt), 233'(30));
        @(negedge clk);
        chk("both_high_noacc", 233'(in_ready), 233'(1));

        // asynchronous reset in the middle of a computation
        start_op(rnd233(), rnd233());
        repeat (10) @(negedge clk);
        chk("mid_cnt", 233'(cnt), 233'(10));
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready",  233'(in_ready),  233'(1));
        chk("mid_rst_out_valid", 233'(out_valid), 233'(0));
        chk("mid_rst_dout",      dout,            233'(0));
        chk("mid_rst_cnt",       233'(cnt),       233'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 233'(in_ready), 233'(1));

        // random operands on the main instance, variable consumer delay
        for (int k = 0; k < 8; k++) begin
            ra = rnd233(); rb = rnd233();
            start_op(ra, rb);
            wait_done(lat, last_cnt);
            chk("rand_dout", dout, golden(ra, rb));
            release_out(int'($urandom_range(0, 3)));
        end

        // digit-size sweep: every instance sees the same operands
        for (int op = 0; op < 60; op++) begin
            if (op == 0) begin ra = {233{1'b1}}; rb = {233{1'b1}}; end
            else if (op == 1) begin ra = 233'(1) << 232; rb = 233'(1) << 232; end
            else begin ra = rnd233(); rb = rnd233(); end
            rexp = golden(ra, rb);
            @(negedge clk);
            chk("sw_in_ready", 233'(sw_in_ready), 233'({NSW{1'b1}}));
            sw_din1 = ra; sw_din2 = rb; sw_in_valid = 1'b1;
            @(negedge clk);
            sw_in_valid = 1'b0;
            seen = '0;
            for (int g = 0; g < NSW; g++) lat_sw[g] = -1;
            c = 0;
            while (seen != {NSW{1'b1}} && c < 400) begin
                @(posedge clk);
                c++;
                @(negedge clk);
                for (int g = 0; g < NSW; g++)
                    if (!seen[g] && sw_out_valid[g]) begin
                        seen[g] = 1'b1;
                        lat_sw[g] = c;
                    end
            end
            for (int g = 0; g < NSW; g++) begin
                chk($sformatf("sw_lat_d%0d", sw_d(g)),  233'(lat_sw[g]), 233'(sw_nd(g)));
                chk($sformatf("sw_dout_d%0d", sw_d(g)), sw_dout[g], rexp);
                chk($sformatf("sw_cnt_d%0d", sw_d(g)),  233'(sw_cnt[g]), 233'(sw_nd(g)));
            end
            sw_out_ready = 1'b1;
            @(negedge clk);
            sw_out_ready = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
